// File: rtl/imm_gen_pipe_if.sv
// Decode-stage handshake bundle for imm_gen_pipe: upstream valid/ready/inst/pc
// and the registered result toward the operand mux.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator (I/S/B/U/J/shamt) with valid/ready, stall and flush.
// Optional one-entry skid buffer enabled by defining IMM_GEN_SKID_EN.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_ARITH_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_ARITH      = 7'b0110011;
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  // Size casts of signed operands sign-extend to exactly XLEN bits.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d.imm     = '0;
    d.fmt     = FMT_NONE;
    d.illegal = 1'b0;
    case (inst[6:0])
      OPC_ARITH_IMM: begin
        if (inst[13:12] == 2'b01) begin
          d.fmt = FMT_SHAMT;
          d.imm = XLEN'(inst[20 +: SHAMT_W]);
        end else begin
          d.fmt = FMT_I;
          d.imm = XLEN'($signed(inst[31:20]));
        end
      end
      OPC_LOAD, OPC_JALR: begin
        d.fmt = FMT_I;
        d.imm = XLEN'($signed(inst[31:20]));
      end
      OPC_STORE: begin
        d.fmt = FMT_S;
        d.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OPC_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        d.fmt = FMT_J;
        d.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OPC_ARITH: ;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q,  out_inst_d;
  logic [XLEN-1:0] out_pc_q,    out_pc_d;
  dec_t            out_dec_q,   out_dec_d;
  dec_t            in_dec;
  logic            out_free;
  logic            accept;

  assign in_dec   = decode(bus.in_inst);
  assign out_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready && !flush;

`ifdef IMM_GEN_SKID_EN
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_inst_q,  skid_inst_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  dec_t            skid_dec;

  assign skid_dec     = decode(skid_inst_q);
  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign bus.in_ready = !skid_valid_q;
`else
  assign bus.in_ready = out_free;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_dec_d   = out_dec_q;
`ifdef IMM_GEN_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so nothing new arrives here.
        out_valid_d  = 1'b1;
        out_inst_d   = skid_inst_q;
        out_pc_d     = skid_pc_q;
        out_dec_d    = skid_dec;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_inst_d = bus.in_inst;
          out_pc_d   = bus.in_pc;
          out_dec_d  = in_dec;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = bus.in_inst;
      skid_pc_d    = bus.in_pc;
    end
`else
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = bus.in_inst;
      out_pc_d    = bus.in_pc;
      out_dec_d   = in_dec;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_dec_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_dec_q   <= out_dec_d;
    end
  end

`ifdef IMM_GEN_SKID_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
`endif

  assign bus.out_valid   = out_valid_q;
  assign bus.out_inst    = out_inst_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_dec_q.imm;
  assign bus.out_fmt     = out_dec_q.fmt;
  assign bus.out_illegal = out_dec_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_inst   = in_inst;
  assign b32.in_pc     = in_pc[31:0];
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_inst   = in_inst;
  assign b64.in_pc     = in_pc;
  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64));

  localparam int NV = 14;
  localparam logic [31:0] V_INST [NV] = '{
    32'hFFF00093, 32'h123450B7, 32'hFE000EE3, 32'h0080006F, 32'h00309093,
    32'h4030D093, 32'h43F0D093, 32'h00112623, 32'hFE112E23, 32'h002081B3,
    32'h0000007F, 32'hFFFFF117, 32'h80002083, 32'h000080E7};
  localparam logic [31:0] V_IMM32 [NV] = '{
    32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'h00000003,
    32'h00000003, 32'h0000001F, 32'h0000000C, 32'hFFFFFFFC, 32'h00000000,
    32'h00000000, 32'hFFFFF000, 32'hFFFFF800, 32'h00000000};
  localparam logic [63:0] V_IMM64 [NV] = '{
    64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC,
    64'h0000000000000008, 64'h0000000000000003, 64'h0000000000000003,
    64'h000000000000003F, 64'h000000000000000C, 64'hFFFFFFFFFFFFFFFC,
    64'h0000000000000000, 64'h0000000000000000, 64'hFFFFFFFFFFFFF000,
    64'hFFFFFFFFFFFFF800, 64'h0000000000000000};
  localparam logic [2:0] V_FMT [NV] = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd6, 3'd6, 3'd6,
                                        3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd1, 3'd1};
  localparam logic V_ILL [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Stream of four addi's; out_ready low in cycles 2 and 3.
  localparam logic [31:0] S_INST [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
  localparam logic        S_OV   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] S_IMM  [8] = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd4, 32'd0};
`ifdef IMM_GEN_SKID_EN
  localparam logic        S_RDY  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
  localparam logic        S_RDY  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic hs;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_inst   = '0;
    in_pc     = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ov",   64'(b32.out_valid),   64'd0);
    check("rst_inst", 64'(b32.out_inst),    64'd0);
    check("rst_pc",   64'(b32.out_pc),      64'd0);
    check("rst_imm",  64'(b32.out_imm),     64'd0);
    check("rst_fmt",  64'(b32.out_fmt),     64'd0);
    check("rst_ill",  64'(b32.out_illegal), 64'd0);
    check("rst_imm64", b64.out_imm,         64'd0);
    check("rst_rdy",  64'(b32.in_ready),    64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single-instruction vectors, each checked one cycle after its accept edge.
    for (int i = 0; i < NV; i++) begin
      tick();
      in_valid = 1'b1;
      in_inst  = V_INST[i];
      in_pc    = 64'hA5A5_0000_0000_1000 + 64'(i * 4);
      tick();
      in_valid = 1'b0;
      in_inst  = 32'hDEADBEEF;
      #1;
      check($sformatf("v%0d_ov", i),    64'(b32.out_valid),   64'd1);
      check($sformatf("v%0d_imm", i),   64'(b32.out_imm),     64'(V_IMM32[i]));
      check($sformatf("v%0d_fmt", i),   64'(b32.out_fmt),     64'(V_FMT[i]));
      check($sformatf("v%0d_ill", i),   64'(b32.out_illegal), 64'(V_ILL[i]));
      check($sformatf("v%0d_inst", i),  64'(b32.out_inst),    64'(V_INST[i]));
      check($sformatf("v%0d_pc", i),    64'(b32.out_pc),      64'h0000_1000 + 64'(i * 4));
      check($sformatf("v%0d_imm64", i), b64.out_imm,          V_IMM64[i]);
      check($sformatf("v%0d_fmt64", i), 64'(b64.out_fmt),     64'(V_FMT[i]));
      check($sformatf("v%0d_pc64", i),  b64.out_pc,           64'hA5A5_0000_0000_1000 + 64'(i * 4));
    end
    tick();
    #1;
    check("drain_ov", 64'(b32.out_valid), 64'd0);

    // Back-to-back stream with a two-cycle stall.
    k  = 0;
    hs = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (hs) k++;
      in_valid  = (k < 4);
      in_inst   = (k < 4) ? S_INST[k] : 32'h0;
      in_pc     = 64'h2000 + 64'(k * 4);
      out_ready = !(c == 2 || c == 3);
      #1;
      check($sformatf("s%0d_ov", c),  64'(b32.out_valid), 64'(S_OV[c]));
      check($sformatf("s%0d_rdy", c), 64'(b32.in_ready),  64'(S_RDY[c]));
      if (S_OV[c]) check($sformatf("s%0d_imm", c), 64'(b32.out_imm), 64'(S_IMM[c]));
      hs = in_valid && b32.in_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Flush with one entry in flight and a new instruction offered.
    tick();
    in_valid  = 1'b1;
    in_inst   = 32'h00500093;
    out_ready = 1'b0;
    tick();
    in_inst = 32'h00600093;
    flush   = 1'b1;
    #1;
    check("fl_pre_ov", 64'(b32.out_valid), 64'd1);
    check("fl_pre_imm", 64'(b32.out_imm),  64'd5);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("fl_ov",  64'(b32.out_valid), 64'd0);
    check("fl_rdy", 64'(b32.in_ready),  64'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      check($sformatf("fl_stale%0d", c), 64'(b32.out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream, then accept on the first edge after release.
    tick();
    in_valid  = 1'b1;
    in_inst   = 32'h123450B7;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    check("ar_pre_ov", 64'(b32.out_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_ov",   64'(b32.out_valid), 64'd0);
    check("ar_imm",  64'(b32.out_imm),   64'd0);
    check("ar_inst", 64'(b32.out_inst),  64'd0);
    check("ar_fmt",  64'(b32.out_fmt),   64'd0);
    check("ar_imm64", b64.out_imm,       64'd0);
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("ar_post_ov",  64'(b32.out_valid), 64'd1);
    check("ar_post_imm", 64'(b32.out_imm),   64'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
